decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second pipeline stage of the 16-bit, 8-bit-PC core; sits directly downstream of the fetch stage.
- Consumes fetch outputs (instruction, PC, valid) and drives fetch control (stall, flush, PC_sel, branch_target).
- Decodes opcodes and reads operands from an internal 8x16 register file with write-back bypass.
- Resolves branches/jumps in decode, detects hazards, and registers a decoded ID/EX bundle for execute.

Parameters:
- DATA_W, 16, register/operand width (ISA fixed to 16).
- PC_W, 8, program-counter width.
- NREG, 8, architectural registers; r0 reads 0.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- instruction  in  16  instruction from fetch
- PC_in  in  8  PC of that instruction
- valid_in  in  1  fetch output is valid
- wb_en  in  1  write-back enable
- wb_rd  in  3  write-back register
- wb_data  in  16  write-back value
- stall  out  1  hold fetch (combinational)
- flush  out  1  squash fetch capture (combinational)
- PC_sel  out  1  redirect fetch PC (combinational)
- branch_target  out  8  redirect address (combinational)
- id_valid  out  1  ID/EX bundle valid
- id_op  out  4  opcode
- id_rd  out  3  destination
- id_rs1  out  3  source A index
- id_rs2  out  3  source B index
- id_a  out  16  operand A value
- id_b  out  16  operand B value
- id_imm  out  16  sign-extended immediate
- id_pc  out  8  instruction PC
- id_reg_write, id_mem_read, id_mem_write  out  1 each  control bits
- illegal  out  1  one-cycle pulse: illegal opcode issued

Behaviour:
- ISA fields: op=[15:12], ra=[11:9], rb=[8:6], rc=[5:3], imm6=[5:0] (sign-extended), imm8=[7:0].
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR: rd=ra, srcs rb,rc
  - 5 ADDI: rd=ra, src rb, imm6
  - 6 LD: rd=ra, base rb, imm6; mem_read
  - 7 ST: data ra, base rb, imm6; mem_write
  - 8 BEQ, 9 BNE: compare ra vs rb
  - A JMP: target imm8
  - B-F illegal: issued as NOP, illegal=1
- Effective instruction: hold register while hold_valid=1, else instruction/PC_in/valid_in.
- Register file: write at posedge when wb_en and wb_rd!=0. Reads are combinational. Bypass: wb_en and wb_rd==src and src!=0 returns wb_data.
- Hazard (effective valid, ID/EX valid, ID/EX rd!=0):
  - Load-use: ID/EX is LD and its rd matches any used source.
  - Branch-compare: BEQ/BNE and ID/EX reg_write rd matches ra or rb.
  - On hazard: stall=1; ID/EX loads a bubble (id_valid=0, all control 0); effective instruction captured into hold (hold_valid=1).
  - Fetch drops valid during stall, so the hold register is mandatory.
- Hold register clears on the first non-stalled cycle.
- Taken branch (BEQ equal / BNE unequal, no hazard):
  - PC_sel=1 and flush=1 for exactly that cycle.
  - branch_target = PC+1+sext(imm6), mod 256; wrap-around is legal.
- JMP: always taken, target = imm8.
- Hazard priority: branch redirect is suppressed while stall=1.
- Branch/JMP issue to ID/EX with id_valid=1 and no reg/mem writes.
- No delay slot. The squashed fetch arrives with valid_in=0 and becomes a bubble.
- Latency: one cycle from effective instruction to the ID/EX bundle.
- Reset: all registered outputs 0, hold_valid=0, register file cleared. Combinational stall/flush/PC_sel/branch_target forced 0 while reset=1.
- Reset mid-stall discards the held instruction.

Decomposition:
- Package decode_pkg: opcode constants, field bit positions, decoded-bundle struct, sign-extension function.
- Sub-module regfile_8x16: 2 read ports, 1 write port, r0 hardwired, write-through bypass.

Test Plan:
- ADD r1,r2,r3 with r2=5, r3=7 -> next cycle id_valid=1, id_op=1, id_a=5, id_b=7, id_rd=1; stall=flush=0.
- LD r1 then ADD r2,r1,r1 back-to-back -> stall=1 one cycle, bubble in ID/EX, then ADD issues with correct PC; fetch sequence unbroken.
- BEQ r1,r2,+3 at PC=0x10 with r1=r2 -> PC_sel=flush=1, branch_target=0x14. With r1!=r2 -> no redirect.
- BNE at PC=0xFE, imm6=+4 with unequal regs -> branch_target=0x03 (wrap). JMP 0x40 -> target 0x40.
- ADDI r3 followed by BEQ r3,r0 -> one stall, then branch resolves using the bypassed wb_data.
- Opcode 0xC -> illegal pulses 1 cycle, bundle is a NOP. Reset asserted during a stall -> all outputs 0, hold cleared.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, instruction field
// positions, the registered ID/EX bundle and immediate sign extension.
package decode_pkg;

  localparam int XLEN     = 16;
  localparam int PCLEN    = 8;
  localparam int NUM_REGS = 8;
  localparam int RIDX_W   = 3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RA_HI   = 11;
  localparam int RA_LO   = 9;
  localparam int RB_HI   = 8;
  localparam int RB_LO   = 6;
  localparam int RC_HI   = 5;
  localparam int RC_LO   = 3;
  localparam int IMM6_HI = 5;
  localparam int IMM8_HI = 7;

  typedef struct packed {
    logic              valid;
    logic [3:0]        op;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   imm;
    logic [PCLEN-1:0]  pc;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_bundle_t;

  function automatic logic [XLEN-1:0] sext_imm6(input logic [IMM6_HI:0] imm);
    return {{(XLEN-IMM6_HI-1){imm[IMM6_HI]}}, imm};
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Architectural register file: two combinational read ports, one write port,
// r0 reads zero, and a same-cycle write value is forwarded to the readers.
module regfile_8x16
  import decode_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int NREG   = NUM_REGS,
  parameter int AW     = RIDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     i_rs1_idx,
  input  logic [AW-1:0]     i_rs2_idx,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic [DATA_W-1:0] i_wd
);

  logic [DATA_W-1:0] r_regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Forwarding lets decode see a result written back in the same cycle.
  assign o_rs1_data = (i_rs1_idx == '0)                  ? '0   :
                      (i_we && (i_wa == i_rs1_idx))      ? i_wd :
                                                           r_regs[i_rs1_idx];
  assign o_rs2_data = (i_rs2_idx == '0)                  ? '0   :
                      (i_we && (i_wa == i_rs2_idx))      ? i_wd :
                                                           r_regs[i_rs2_idx];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction decode, operand read, branch/jump resolution,
// load-use and branch-compare hazard stalls, and the registered ID/EX bundle.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int PC_W   = PCLEN,
  parameter int NREG   = NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic [PC_W-1:0]   PC_in,
  input  logic              valid_in,
  input  logic              wb_en,
  input  logic [2:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              flush,
  output logic              PC_sel,
  output logic [PC_W-1:0]   branch_target,
  output logic              id_valid,
  output logic [3:0]        id_op,
  output logic [2:0]        id_rd,
  output logic [2:0]        id_rs1,
  output logic [2:0]        id_rs2,
  output logic [DATA_W-1:0] id_a,
  output logic [DATA_W-1:0] id_b,
  output logic [DATA_W-1:0] id_imm,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              illegal
);

  id_bundle_t        r_id;
  logic              r_hold_valid;
  logic [15:0]       r_hold_instr;
  logic [PC_W-1:0]   r_hold_pc;
  logic              r_illegal;

  logic [15:0]       w_instr;
  logic [PC_W-1:0]   w_pc;
  logic              w_valid;
  logic [3:0]        w_op;
  logic [2:0]        w_ra, w_rb, w_rc;
  logic [2:0]        w_rd, w_rs1, w_rs2;
  logic              w_use1, w_use2;
  logic [DATA_W-1:0] w_imm, w_a, w_b;
  logic              w_reg_write, w_mem_read, w_mem_write;
  logic              w_is_branch, w_is_jmp, w_illegal;
  logic              w_load_use, w_br_hazard, w_hazard, w_taken;
  logic [PC_W-1:0]   w_target;
  id_bundle_t        w_next;

  // While a stalled instruction is held, fetch is not presenting valid data.
  assign w_instr = r_hold_valid ? r_hold_instr : instruction;
  assign w_pc    = r_hold_valid ? r_hold_pc    : PC_in;
  assign w_valid = r_hold_valid | valid_in;

  assign w_op = w_instr[OP_HI:OP_LO];
  assign w_ra = w_instr[RA_HI:RA_LO];
  assign w_rb = w_instr[RB_HI:RB_LO];
  assign w_rc = w_instr[RC_HI:RC_LO];

  always_comb begin
    w_rd        = '0;
    w_rs1       = '0;
    w_rs2       = '0;
    w_use1      = 1'b0;
    w_use2      = 1'b0;
    w_imm       = '0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_is_branch = 1'b0;
    w_is_jmp    = 1'b0;
    w_illegal   = 1'b0;
    case (w_op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        w_rd = w_ra; w_rs1 = w_rb; w_rs2 = w_rc;
        w_use1 = 1'b1; w_use2 = 1'b1; w_reg_write = 1'b1;
      end
      OP_ADDI, OP_LD: begin
        w_rd = w_ra; w_rs1 = w_rb; w_use1 = 1'b1; w_reg_write = 1'b1;
        w_imm = sext_imm6(w_instr[IMM6_HI:0]);
        w_mem_read = (w_op == OP_LD);
      end
      OP_ST: begin
        w_rs1 = w_rb; w_rs2 = w_ra; w_use1 = 1'b1; w_use2 = 1'b1;
        w_imm = sext_imm6(w_instr[IMM6_HI:0]); w_mem_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_rs1 = w_ra; w_rs2 = w_rb; w_use1 = 1'b1; w_use2 = 1'b1;
        w_imm = sext_imm6(w_instr[IMM6_HI:0]); w_is_branch = 1'b1;
      end
      OP_JMP: begin
        w_imm = {{(DATA_W-IMM8_HI-1){1'b0}}, w_instr[IMM8_HI:0]};
        w_is_jmp = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  regfile_8x16 #(.DATA_W(DATA_W), .NREG(NREG), .AW(RIDX_W)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_idx  (w_rs1),
    .i_rs2_idx  (w_rs2),
    .o_rs1_data (w_a),
    .o_rs2_data (w_b),
    .i_we       (wb_en),
    .i_wa       (wb_rd),
    .i_wd       (wb_data)
  );

  assign w_load_use  = r_id.mem_read &&
                       ((w_use1 && (w_rs1 == r_id.rd)) || (w_use2 && (w_rs2 == r_id.rd)));
  assign w_br_hazard = w_is_branch && r_id.reg_write &&
                       ((w_ra == r_id.rd) || (w_rb == r_id.rd));
  assign w_hazard    = w_valid && r_id.valid && (r_id.rd != '0) &&
                       (w_load_use || w_br_hazard);

  // A redirect is never taken while stalled; operands may still be in flight.
  assign w_taken  = w_valid && !w_hazard &&
                    (w_is_jmp || ((w_op == OP_BEQ) && (w_a == w_b)) ||
                                 ((w_op == OP_BNE) && (w_a != w_b)));
  assign w_target = w_is_jmp ? w_instr[PC_W-1:0]
                             : (w_pc + PC_W'(1) + w_imm[PC_W-1:0]);

  assign stall         = !reset && w_hazard;
  assign flush         = !reset && w_taken;
  assign PC_sel        = !reset && w_taken;
  assign branch_target = (!reset && w_taken) ? w_target : '0;

  always_comb begin
    w_next           = '0;
    w_next.valid     = 1'b1;
    w_next.op        = w_illegal ? OP_NOP : w_op;
    w_next.rd        = w_rd;
    w_next.rs1       = w_rs1;
    w_next.rs2       = w_rs2;
    w_next.a         = w_a;
    w_next.b         = w_b;
    w_next.imm       = w_imm;
    w_next.pc        = w_pc;
    w_next.reg_write = w_reg_write;
    w_next.mem_read  = w_mem_read;
    w_next.mem_write = w_mem_write;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id         <= '0;
      r_hold_valid <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_hold_valid <= w_hazard;
      if (w_hazard) begin
        r_hold_instr <= w_instr;
        r_hold_pc    <= w_pc;
      end
      r_id      <= (w_valid && !w_hazard) ? w_next : '0;
      r_illegal <= w_valid && !w_hazard && w_illegal;
    end
  end

  assign id_valid     = r_id.valid;
  assign id_op        = r_id.op;
  assign id_rd        = r_id.rd;
  assign id_rs1       = r_id.rs1;
  assign id_rs2       = r_id.rs2;
  assign id_a         = r_id.a;
  assign id_b         = r_id.b;
  assign id_imm       = r_id.imm;
  assign id_pc        = r_id.pc;
  assign id_reg_write = r_id.reg_write;
  assign id_mem_read  = r_id.mem_read;
  assign id_mem_write = r_id.mem_write;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX bundles are queued when each
// instruction is driven and compared one clock later; fetch controls are checked in-cycle.
module tb_decode_stage;

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [7:0]  pc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instruction = '0;
  logic [7:0]  PC_in = '0;
  logic        valid_in = 1'b0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_rd = '0;
  logic [15:0] wb_data = '0;
  logic        stall, flush, PC_sel;
  logic [7:0]  branch_target;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [2:0]  id_rd, id_rs1, id_rs2;
  logic [15:0] id_a, id_b, id_imm;
  logic [7:0]  id_pc;
  logic        id_reg_write, id_mem_read, id_mem_write, illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .instruction(instruction), .PC_in(PC_in),
    .valid_in(valid_in), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .flush(flush), .PC_sel(PC_sel), .branch_target(branch_target),
    .id_valid(id_valid), .id_op(id_op), .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_pc(id_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .illegal(illegal)
  );

  function automatic exp_t mk(input logic [3:0] op, input logic [2:0] rd, rs1, rs2,
                              input logic [15:0] a, b, imm, input logic [7:0] pc,
                              input logic rw, mr, mw, ill);
    exp_t e;
    e.v = 1'b1; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.a = a; e.b = b; e.imm = imm; e.pc = pc;
    e.rw = rw; e.mr = mr; e.mw = mw; e.ill = ill;
    return e;
  endfunction

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] ra, rb,
                                      input logic [5:0] low);
    return {op, ra, rb, low};
  endfunction

  function automatic logic [10:0] cm(input logic s, f, input logic [7:0] t);
    return {s, f, f, t};
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.v = id_valid; o.op = id_op; o.rd = id_rd; o.rs1 = id_rs1; o.rs2 = id_rs2;
    o.a = id_a; o.b = id_b; o.imm = id_imm; o.pc = id_pc;
    o.rw = id_reg_write; o.mr = id_mem_read; o.mw = id_mem_write; o.ill = illegal;
    return o;
  endfunction

  task automatic chk_comb(input logic [10:0] e, input string tag);
    logic [10:0] got;
    got = {stall, flush, PC_sel, branch_target};
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s comb stall/flush/pcsel/target: got %h expected %h", tag, got, e);
    end
  endtask

  task automatic chk_bundle(input exp_t e, input string tag);
    exp_t got;
    got = observed();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s bundle: got %h expected %h", tag, got, e);
    end
  endtask

  task automatic cyc(input logic [15:0] ins, input logic [7:0] pc, input logic v,
                     input logic we, input logic [2:0] wrd, input logic [15:0] wd,
                     input logic [10:0] ec, input exp_t eb, input string tag);
    exp_t e;
    @(negedge clk);
    instruction = ins; PC_in = pc; valid_in = v;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    sb.push_back(eb);
    #1;
    chk_comb(ec, tag);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_bundle(e, tag);
    $display("txn %-10s pc=%h v=%b stall=%b flush=%b tgt=%h -> id_valid=%b op=%h a=%h b=%h",
             tag, pc, v, stall, flush, branch_target, id_valid, id_op, id_a, id_b);
  endtask

  initial begin
    exp_t bub;
    bub = '0;

    // Reset with a JMP presented: fetch controls must stay low.
    #1 reset = 1'b1;
    instruction = enc(4'hA, 3'd0, 3'd0, 6'h00) | 16'h0040; valid_in = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk_comb(cm(0, 0, 8'h00), "reset");
    chk_bundle(bub, "reset");
    @(negedge clk);
    reset = 1'b0; valid_in = 1'b0; instruction = '0;

    cyc('0, 8'h00, 0, 1, 3'd2, 16'd5, cm(0, 0, 0), bub, "wb_r2");
    cyc('0, 8'h00, 0, 1, 3'd3, 16'd7, cm(0, 0, 0), bub, "wb_r3");
    cyc(enc(4'h1, 3'd1, 3'd2, {3'd3, 3'd0}), 8'h00, 1, 0, 0, 0, cm(0, 0, 0),
        mk(4'h1, 3'd1, 3'd2, 3'd3, 16'd5, 16'd7, 16'd0, 8'h00, 1, 0, 0, 0), "add");
    cyc(enc(4'h6, 3'd1, 3'd2, 6'd1), 8'h01, 1, 0, 0, 0, cm(0, 0, 0),
        mk(4'h6, 3'd1, 3'd2, 3'd0, 16'd5, 16'd0, 16'd1, 8'h01, 1, 1, 0, 0), "ld");
    cyc(enc(4'h1, 3'd2, 3'd1, {3'd1, 3'd0}), 8'h02, 1, 0, 0, 0, cm(1, 0, 0), bub, "ldu_stall");
    cyc('0, 8'h03, 0, 1, 3'd1, 16'd9, cm(0, 0, 0),
        mk(4'h1, 3'd2, 3'd1, 3'd1, 16'd9, 16'd9, 16'd0, 8'h02, 1, 0, 0, 0), "ldu_replay");
    cyc('0, 8'h03, 0, 1, 3'd2, 16'd9, cm(0, 0, 0), bub, "wb_r2b");
    cyc(enc(4'h8, 3'd1, 3'd2, 6'd3), 8'h10, 1, 0, 0, 0, cm(0, 1, 8'h14),
        mk(4'h8, 3'd0, 3'd1, 3'd2, 16'd9, 16'd9, 16'd3, 8'h10, 0, 0, 0, 0), "beq_taken");
    cyc('0, 8'h11, 0, 0, 0, 0, cm(0, 0, 0), bub, "squash1");
    cyc(enc(4'h8, 3'd1, 3'd3, 6'd3), 8'h14, 1, 0, 0, 0, cm(0, 0, 0),
        mk(4'h8, 3'd0, 3'd1, 3'd3, 16'd9, 16'd7, 16'd3, 8'h14, 0, 0, 0, 0), "beq_not");
    cyc(enc(4'h9, 3'd1, 3'd3, 6'd4), 8'hFE, 1, 0, 0, 0, cm(0, 1, 8'h03),
        mk(4'h9, 3'd0, 3'd1, 3'd3, 16'd9, 16'd7, 16'd4, 8'hFE, 0, 0, 0, 0), "bne_wrap");
    cyc('0, 8'hFF, 0, 0, 0, 0, cm(0, 0, 0), bub, "squash2");
    cyc(16'hA040, 8'h03, 1, 0, 0, 0, cm(0, 1, 8'h40),
        mk(4'hA, 3'd0, 3'd0, 3'd0, 16'd0, 16'd0, 16'h0040, 8'h03, 0, 0, 0, 0), "jmp");
    cyc('0, 8'h04, 0, 0, 0, 0, cm(0, 0, 0), bub, "squash3");
    cyc(enc(4'h5, 3'd3, 3'd2, 6'd1), 8'h40, 1, 0, 0, 0, cm(0, 0, 0),
        mk(4'h5, 3'd3, 3'd2, 3'd0, 16'd9, 16'd0, 16'd1, 8'h40, 1, 0, 0, 0), "addi");
    cyc(enc(4'h8, 3'd3, 3'd0, 6'h3E), 8'h41, 1, 0, 0, 0, cm(1, 0, 0), bub, "br_stall");
    cyc('0, 8'h42, 0, 1, 3'd3, 16'd0, cm(0, 1, 8'h40),
        mk(4'h8, 3'd0, 3'd3, 3'd0, 16'd0, 16'd0, 16'hFFFE, 8'h41, 0, 0, 0, 0), "br_bypass");
    cyc('0, 8'h42, 0, 0, 0, 0, cm(0, 0, 0), bub, "squash4");
    cyc(16'hC123, 8'h42, 1, 0, 0, 0, cm(0, 0, 0),
        mk(4'h0, 3'd0, 3'd0, 3'd0, 16'd0, 16'd0, 16'd0, 8'h42, 0, 0, 0, 1), "illegal");
    cyc(16'h0000, 8'h43, 1, 0, 0, 0, cm(0, 0, 0),
        mk(4'h0, 3'd0, 3'd0, 3'd0, 16'd0, 16'd0, 16'd0, 8'h43, 0, 0, 0, 0), "nop_after");
    cyc(enc(4'h6, 3'd5, 3'd0, 6'd0), 8'h50, 1, 0, 0, 0, cm(0, 0, 0),
        mk(4'h6, 3'd5, 3'd0, 3'd0, 16'd0, 16'd0, 16'd0, 8'h50, 1, 1, 0, 0), "ld_r5");

    // Load-use stall on ADD r6,r5,r5, then reset lands inside that stall.
    @(negedge clk);
    instruction = enc(4'h1, 3'd6, 3'd5, {3'd5, 3'd0}); PC_in = 8'h51; valid_in = 1'b1;
    wb_en = 1'b0;
    #1 chk_comb(cm(1, 0, 0), "rst_stall_pre");
    #1 reset = 1'b1;
    #1 chk_comb(cm(0, 0, 0), "rst_stall");
    chk_bundle(bub, "rst_stall");
    $display("txn %-10s reset asserted during stall, id_valid=%b stall=%b", "rst_stall", id_valid, stall);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    cyc('0, 8'h52, 0, 0, 0, 0, cm(0, 0, 0), bub, "post_rst");
    cyc(enc(4'h1, 3'd1, 3'd2, {3'd3, 3'd0}), 8'h60, 1, 0, 0, 0, cm(0, 0, 0),
        mk(4'h1, 3'd1, 3'd2, 3'd3, 16'd0, 16'd0, 16'd0, 8'h60, 1, 0, 0, 0), "rf_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
